// File: rtl/vec_mem_ctrl_if.sv
// Bundle of the request, store-data, load-data, memory and status signals of vec_mem_ctrl.
// master: the requester/memory side; slave: the controller itself.
interface vec_mem_ctrl_if;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_base;
    logic [3:0]      req_len;
    logic            wd_valid;
    logic            wd_ready;
    logic [5:0][7:0] wd_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [5:0][7:0] rd_data;
    logic [31:0]     A;
    logic            WE;
    logic [5:0][7:0] WD;
    logic [5:0][7:0] RD;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output req_valid, req_we, req_base, req_len, wd_valid, wd_data, rd_ready, RD,
        input  req_ready, wd_ready, rd_valid, rd_data, A, WE, WD, busy, done, err
    );

    modport slave (
        input  req_valid, req_we, req_base, req_len, wd_valid, wd_data, rd_ready, RD,
        output req_ready, wd_ready, rd_valid, rd_data, A, WE, WD, busy, done, err
    );
endinterface

// File: rtl/vec_mem_ctrl.sv
// Burst load/store controller between a request port and a 48-bit word memory.
// Loads are registered onto a ready/valid stream; stores pass wd_data straight to WD.
// Optional macro VMEM_BOUNDS_CHECK_EN: reject requests whose last word index
// reaches MEM_WORDS with a one-cycle err pulse instead of executing them.
module vec_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 102
) (
    input  logic          clk,
    input  logic          rst,
    vec_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StDrain,
        StDone
    } state_e;

`ifdef VMEM_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic [5:0][7:0] rd_data_q, rd_data_d;
    logic [31:0]     last_idx;
    logic            oob;
    logic            accept;

    // Word index of the last beat; cannot overflow 32 bits (30-bit index + 4-bit length).
    assign last_idx = {2'b00, bus.req_base[31:2]} + {28'd0, bus.req_len};
    assign oob      = BoundsEn && (last_idx >= MEM_WORDS);
    assign accept   = bus.req_valid && (state_q == StIdle);

    // Next-state, address/count and load-register update
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q && !bus.rd_ready;
        rd_data_d  = rd_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = {bus.req_base[31:2], 2'b00};
                    cnt_d  = bus.req_len;
                    if (!oob) begin
                        state_d = bus.req_we ? StStore : StLoad;
                    end
                end
            end
            StLoad: begin
                // A new word is taken only when the output register is free or being drained
                if (!rd_valid_q || bus.rd_ready) begin
                    rd_data_d  = bus.RD;
                    rd_valid_d = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + 32'd4;
                        cnt_d  = cnt_q - 4'd1;
                    end
                end
            end
            StStore: begin
                if (bus.wd_valid) begin
                    if (cnt_q == 4'd0) begin
                        state_d = StDone;
                    end else begin
                        addr_d = addr_q + 32'd4;
                        cnt_d  = cnt_q - 4'd1;
                    end
                end
            end
            StDrain: begin
                if (!rd_valid_q || bus.rd_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= 32'd0;
            cnt_q      <= 4'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef VMEM_BOUNDS_CHECK_EN
    logic err_q, err_d;

    assign err_d   = accept && oob;
    assign bus.err = err_q;

    // Rejected request reports one cycle after it is consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.wd_ready  = (state_q == StStore);
    assign bus.WE        = (state_q == StStore) && bus.wd_valid;
    assign bus.WD        = bus.wd_data;
    assign bus.A         = addr_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: doc/vec_mem_ctrl.md
VEC_MEM_CTRL -- requirements
Module: vec_mem_ctrl

Interface
REQ-001 The block SHALL expose parameter MEM_WORDS, default 102, meaning the number of 48-bit words in the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a transfer request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: a request can be accepted; equals (state==IDLE).
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store burst, 0 = load burst.
REQ-007 The block SHALL have port req_base, input, 32 bits: byte address of the first word; bits [1:0] are ignored.
REQ-008 The block SHALL have port req_len, input, 4 bits: word count minus 1 (1..16 words).
REQ-009 The block SHALL have port wd_valid, input, 1 bit, and port wd_data, input, [5:0][7:0]: store data stream.
REQ-010 The block SHALL have port wd_ready, output, 1 bit: store word accepted this cycle when wd_valid is also high.
REQ-011 The block SHALL have port rd_valid, output, 1 bit, and port rd_data, output, [5:0][7:0]: registered load data stream.
REQ-012 The block SHALL have port rd_ready, input, 1 bit: consumer accepts rd_data.
REQ-013 The block SHALL have port A, output, 32 bits: memory byte address, bits [1:0] always 0.
REQ-014 The block SHALL have ports WE, output, 1 bit, and WD, output, [5:0][7:0]: memory write strobe and data; WD = wd_data.
REQ-015 The block SHALL have port RD, input, [5:0][7:0]: combinational memory read data for address A.
REQ-016 The block SHALL have ports busy (state!=IDLE), done (one-cycle pulse) and err (one-cycle pulse), each an output of 1 bit.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, STORE, DRAIN and DONE.
REQ-018 In IDLE, req_valid&&req_ready SHALL latch addr<={req_base[31:2],2'b00} and cnt<=req_len, then go to STORE if req_we, else to LOAD.
REQ-019 In LOAD, when (!rd_valid||rd_ready), the block SHALL register rd_data<=RD and set rd_valid<=1; if cnt==0 it SHALL go to DRAIN, else addr+=4 and cnt-=1.
REQ-020 In LOAD with rd_valid&&!rd_ready, the block SHALL hold A, rd_data and cnt unchanged.
REQ-021 rd_valid SHALL clear on rd_ready when no new word is registered in the same cycle; the first load word appears 2 cycles after acceptance.
REQ-022 DRAIN SHALL go to DONE in the cycle where rd_valid is 0, or where rd_valid&&rd_ready.
REQ-023 In STORE, wd_ready SHALL be 1 and WE=wd_valid (combinational); on wd_valid, addr+=4 and cnt-=1, or go to DONE if cnt==0.
REQ-024 WE SHALL be 0 in every state other than STORE.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 Address arithmetic SHALL be 32-bit unsigned modulo 2^32 (wraps at 0xFFFFFFFC to 0).
REQ-027 A request SHALL never be accepted while busy, since req_ready is 0.

Reset
REQ-028 On rst==0 the block SHALL immediately enter IDLE with addr=0, cnt=0, rd_valid=0, rd_data=0, done=0 and err=0; hence WE=0 and req_ready=1.
REQ-029 Reset mid-burst SHALL abort the burst without a done pulse; memory writes already performed remain.

Configuration
REQ-030 With VMEM_BOUNDS_CHECK_EN defined, a request whose last word index (req_base[31:2]+req_len) >= MEM_WORDS SHALL be consumed with one err pulse in the next cycle, with no memory access and no done pulse.
REQ-031 Without VMEM_BOUNDS_CHECK_EN, no bounds check SHALL be performed, err SHALL be tied to 0, and every accepted request SHALL execute.

Verification
REQ-032 Load: base=0x10, len=2, rd_ready=1, RAM[4..6]=words X,Y,Z -> X,Y,Z appear on consecutive cycles starting 2 cycles after acceptance; A=0x10,0x14,0x18; done 1 cycle after Z.
REQ-033 Load backpressure: same request with rd_ready low for 3 cycles after the first word -> X held stable, A stays 0x14, no word lost or duplicated.
REQ-034 Store: base=0x20, len=1, wd_valid gapped (1,0,1) -> WE pulses with A=0x20 then 0x24; RAM[8] and RAM[9] are written; done follows.
REQ-035 Bounds (macro on): base=0x190 (index 100), len=3 -> err pulse, no WE, no rd_valid, req_ready=1 again; macro off -> 4 words are accessed.
REQ-036 Reset asserted during the 2nd store beat -> WE drops asynchronously, state IDLE, no done; next request executes normally.
